// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg : shared state encoding and bubble constant for stage registers
// Rev 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY     = 2'd0,
    PS_FULL      = 2'd1,
    PS_SKID_FULL = 2'd2
  } ps_state_e;

  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

  // Occupancy is carried entirely by the slot valid bits; this names it.
  function automatic ps_state_e ps_decode(input logic main_v, input logic skid_v);
    if (skid_v)      return PS_SKID_FULL;
    else if (main_v) return PS_FULL;
    else             return PS_EMPTY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_slot : one valid+payload register with load, drop and kill-to-bubble
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_slot #(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drop,
  input  logic         kill,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Kill beats load beats drop; a dropped entry keeps its payload visible.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_stage_reg : valid/ready pipeline register, optional skid, flush, stall counter
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 SKID      = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(C_NOP_INSTR),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc_plus_4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus_4,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int              PW     = INSTR_W + PC_W;
  localparam logic [PW-1:0]   BUBBLE = {NOP_INSTR, {PC_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ps_state_e       state;
  logic            in_xfer, out_xfer;
  logic            main_load, main_drop, skid_load, skid_drop;
  logic            main_valid, skid_valid;
  logic [PW-1:0]   main_src, main_data, skid_data;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    state     = ps_decode(main_valid, skid_valid);
    in_xfer   = in_valid && in_ready;
    out_xfer  = main_valid && out_ready;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    main_src  = {in_instr, in_pc_plus_4};
    unique case (state)
      PS_EMPTY: main_load = in_xfer;
      PS_FULL: begin
        // Without a skid slot, in_ready forces in_xfer to imply out_xfer here.
        if (in_xfer && out_xfer) main_load = 1'b1;
        else if (in_xfer)        skid_load = 1'b1;
        else if (out_xfer)       main_drop = 1'b1;
      end
      PS_SKID_FULL: begin
        if (out_xfer) begin
          main_load = 1'b1;
          main_src  = skid_data;
          skid_drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pipe_slot #(
    .W       (PW),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .drop      (main_drop),
    .kill      (flush),
    .load_data (main_src),
    .valid     (main_valid),
    .data      (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .W       (PW),
      .RST_VAL ({PW{1'b0}})
    ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (skid_load),
      .drop      (skid_drop),
      .kill      (flush),
      .load_data ({in_instr, in_pc_plus_4}),
      .valid     (skid_valid),
      .data      (skid_data)
    );
    // Registered ready: depends only on a flop, never on out_ready.
    assign in_ready = !skid_valid;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = {PW{1'b0}};
    assign in_ready   = !main_valid || out_ready;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid                  = main_valid;
  assign {out_instr, out_pc_plus_4} = main_data;
  assign stall_cnt                  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg : directed vector table plus hand sequences for corner cases
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic        ov, ir, ov2, ir2, ov0, ir0;
  logic [31:0] oi, op, oi2, op2, oi0, op0;
  logic [15:0] sc, sc0;
  logic [1:0]  sc2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir),
    .in_instr(in_instr), .in_pc_plus_4(in_pc), .flush(flush),
    .out_valid(ov), .out_ready(out_ready), .out_instr(oi),
    .out_pc_plus_4(op), .stall_cnt(sc)
  );

  pipe_stage_reg #(.SKID(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .in_instr(in_instr), .in_pc_plus_4(in_pc), .flush(flush),
    .out_valid(ov2), .out_ready(out_ready), .out_instr(oi2),
    .out_pc_plus_4(op2), .stall_cnt(sc2)
  );

  pipe_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(ir0),
    .in_instr(in_instr), .in_pc_plus_4(in_pc), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready0), .out_instr(oi0),
    .out_pc_plus_4(op0), .stall_cnt(sc0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        er;
    int          es;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic iv, input logic [31:0] i, input logic [31:0] p,
                              input logic o, input logic f, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic er, input int es);
    vec_t v;
    v.iv = iv; v.instr = i; v.pc = p; v.ordy = o; v.fl = f;
    v.ev = ev; v.ei = ei; v.ep = ep; v.er = er; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs: iv, instr, pc, out_ready, flush | after edge: out_valid, instr, pc, in_ready, stall
    vt[0]  = mk(1, 32'h12345678, 32'h4,  1, 0,  1, 32'h12345678, 32'h4,  1, 0);
    vt[1]  = mk(1, 32'h87654321, 32'h8,  1, 0,  1, 32'h87654321, 32'h8,  1, 0);
    vt[2]  = mk(1, 32'hDEADBEEF, 32'hC,  1, 0,  1, 32'hDEADBEEF, 32'hC,  1, 0);
    vt[3]  = mk(0, 32'h0,        32'h0,  1, 0,  0, 32'hDEADBEEF, 32'hC,  1, 0);
    vt[4]  = mk(1, 32'h12345678, 32'h4,  0, 0,  1, 32'h12345678, 32'h4,  1, 0);
    vt[5]  = mk(1, 32'h87654321, 32'h8,  0, 0,  1, 32'h12345678, 32'h4,  0, 1);
    vt[6]  = mk(1, 32'hDEADBEEF, 32'hC,  0, 0,  1, 32'h12345678, 32'h4,  0, 2);
    vt[7]  = mk(1, 32'hDEADBEEF, 32'hC,  1, 0,  1, 32'h87654321, 32'h8,  1, 2);
    vt[8]  = mk(0, 32'h0,        32'h0,  1, 0,  0, 32'h87654321, 32'h8,  1, 2);
    vt[9]  = mk(1, 32'h12345678, 32'h4,  0, 0,  1, 32'h12345678, 32'h4,  1, 2);
    vt[10] = mk(1, 32'h87654321, 32'h8,  0, 0,  1, 32'h12345678, 32'h4,  0, 3);
    vt[11] = mk(1, 32'hDEADBEEF, 32'hC,  0, 1,  0, 32'h0,        32'h0,  1, 4);
    vt[12] = mk(0, 32'h0,        32'h0,  1, 0,  0, 32'h0,        32'h0,  1, 4);
    vt[13] = mk(1, 32'h11111111, 32'h10, 1, 0,  1, 32'h11111111, 32'h10, 1, 4);
    vt[14] = mk(1, 32'h22222222, 32'h14, 1, 1,  0, 32'h0,        32'h0,  1, 4);
    vt[15] = mk(1, 32'h33333333, 32'h18, 0, 0,  1, 32'h33333333, 32'h18, 1, 4);
    vt[16] = mk(0, 32'h0,        32'h0,  0, 0,  1, 32'h33333333, 32'h18, 1, 5);
    vt[17] = mk(0, 32'h0,        32'h0,  1, 0,  0, 32'h33333333, 32'h18, 1, 5);

    do_reset();
    chk("rst.out_valid", ov, 0);
    chk("rst.out_instr", oi, 32'h0);
    chk("rst.out_pc", op, 32'h0);
    chk("rst.in_ready", ir, 1);
    chk("rst.stall_cnt", sc, 0);
    chk("rst.c2_stall_cnt", sc2, 0);
    chk("rst.skid0_in_ready", ir0, 1);
    chk("rst.skid0_out_valid", ov0, 0);

    for (int i = 0; i < 18; i++) begin
      in_valid  = vt[i].iv;
      in_instr  = vt[i].instr;
      in_pc     = vt[i].pc;
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      tick();
      chk($sformatf("v%0d.out_valid", i), ov, vt[i].ev);
      chk($sformatf("v%0d.out_instr", i), oi, vt[i].ei);
      chk($sformatf("v%0d.out_pc", i), op, vt[i].ep);
      chk($sformatf("v%0d.in_ready", i), ir, vt[i].er);
      chk($sformatf("v%0d.stall_cnt", i), sc, vt[i].es);
      chk($sformatf("v%0d.c2_stall_cnt", i), sc2, (vt[i].es > 3) ? 3 : vt[i].es);
    end
    in_valid = 0; out_ready = 0; flush = 0;

    // Five stall cycles from a fresh reset: wide counter reads 5, 2-bit counter pins at 3.
    do_reset();
    in_valid = 1; in_instr = 32'hA5A5A5A5; in_pc = 32'h20; out_ready = 0;
    tick();
    in_valid = 0;
    repeat (5) tick();
    chk("stall.out_valid", ov, 1);
    chk("stall.out_instr", oi, 32'hA5A5A5A5);
    chk("stall.cnt5", sc, 5);
    chk("stall.c2_sat", sc2, 3);

    // Asynchronous reset in mid-cycle, no clock edge in between.
    #2 rst_n = 0;
    #1;
    chk("async_rst.out_valid", ov, 0);
    chk("async_rst.stall_cnt", sc, 0);
    chk("async_rst.c2_stall_cnt", sc2, 0);
    chk("async_rst.out_instr", oi, 32'h0);
    chk("async_rst.in_ready", ir, 1);
    #3 rst_n = 1;
    tick();

    // Single-register mode: back-to-back stream, then combinational ready under back-pressure.
    do_reset();
    out_ready0 = 1;
    in_valid0  = 1;
    for (int k = 0; k < 3; k++) begin
      in_instr = (k == 0) ? 32'h12345678 : (k == 1) ? 32'h87654321 : 32'hDEADBEEF;
      in_pc    = 32'(4 * (k + 1));
      #1;
      chk($sformatf("s0.k%0d.in_ready", k), ir0, 1);
      tick();
      chk($sformatf("s0.k%0d.out_valid", k), ov0, 1);
      chk($sformatf("s0.k%0d.out_instr", k), oi0, in_instr);
      chk($sformatf("s0.k%0d.out_pc", k), op0, 32'(4 * (k + 1)));
    end
    in_instr = 32'h55555555; in_pc = 32'h10; out_ready0 = 0;
    #1;
    chk("s0.bp.in_ready_low", ir0, 0);
    tick();
    chk("s0.bp.held_instr", oi0, 32'hDEADBEEF);
    chk("s0.bp.stall_cnt", sc0, 1);
    out_ready0 = 1;
    #1;
    chk("s0.bp.in_ready_high", ir0, 1);
    tick();
    chk("s0.bp.next_instr", oi0, 32'h55555555);
    chk("s0.bp.next_valid", ov0, 1);
    in_valid0 = 0;
    tick();
    chk("s0.drain.out_valid", ov0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
